// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the 64-bit ALU and its two-requester front end:
//   - ALU control op-codes (the ALU decodes the same constants)
//   - state encoding of the alu_arbiter sequencing FSM
//   - is_legal_op: true for the five control codes the ALU implements
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arbState_t;

    function automatic logic is_legal_op(input logic [3:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Requester-side bundle of the ALU front end: two request channels
// (Valid/Ready, operands, control code) and two response channels
// (Valid/Ready, result, zero flag, illegal-op flag).
//   master : the requesters (drive requests, consume responses)
//   slave  : alu_arbiter (accepts requests, produces responses)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4
);
    logic              Req0Valid, Req1Valid;
    logic              Req0Ready, Req1Ready;
    logic [DATA_W-1:0] Req0A, Req0B, Req1A, Req1B;
    logic [CTRL_W-1:0] Req0Ctrl, Req1Ctrl;

    logic              Resp0Valid, Resp1Valid;
    logic              Resp0Ready, Resp1Ready;
    logic [DATA_W-1:0] Resp0W, Resp1W;
    logic              Resp0Zero, Resp1Zero;
    logic              Resp0Err, Resp1Err;

    modport master (
        output Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B,
               Req0Ctrl, Req1Ctrl, Resp0Ready, Resp1Ready,
        input  Req0Ready, Req1Ready, Resp0Valid, Resp1Valid,
               Resp0W, Resp1W, Resp0Zero, Resp1Zero, Resp0Err, Resp1Err
    );

    modport slave (
        input  Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B,
               Req0Ctrl, Req1Ctrl, Resp0Ready, Resp1Ready,
        output Req0Ready, Req1Ready, Resp0Valid, Resp1Valid,
               Resp0W, Resp1W, Resp0Zero, Resp1Zero, Resp0Err, Resp1Err
    );
endinterface

// File: rtl/alu_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin grant. A lone request always wins; when both request,
// the priority pointer picks the winner. The pointer moves to the requester
// that was not served whenever 'advance' is pulsed.
//   clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//   req[1:0]   : request vector
//   advance    : pulse when the served requester's transaction completes
//   servedId   : id of the requester that was just served
//   gnt[1:0]   : one-hot (or zero) grant, combinational
// -----------------------------------------------------------------------------
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       servedId,
    output logic [1:0] gnt
);
    logic ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~servedId;
        end
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational 64-bit ALU between two requesters. An operation is
// accepted in IDLE, evaluated by the ALU from registered operands in EXEC, and
// its result is held on the winner's response channel in RESP until consumed.
//   CLK, Reset      : clock, synchronous active-high reset
//   bus (slave)     : two request and two response channels
//   AluA/AluB       : to ALU BusA/BusB
//   AluCtrl         : to ALU control input
//   AluW/AluZero    : from ALU result and zero flag
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    output logic [CTRL_W-1:0] AluCtrl,
    input  logic [DATA_W-1:0] AluW,
    input  logic              AluZero
);
    arbState_t         state, stateNext;
    logic [1:0]        gnt;
    logic              accept, respDone, opLegal;

    logic              grantId;
    logic [DATA_W-1:0] opA, opB;
    logic [CTRL_W-1:0] opCtrl;
    logic [DATA_W-1:0] resW;
    logic              resZero, resErr;

    rr_arbiter_2 uArb (
        .clk      (CLK),
        .rst      (Reset),
        .req      ({bus.Req1Valid, bus.Req0Valid}),
        .advance  (respDone),
        .servedId (grantId),
        .gnt      (gnt)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Ready is gated by Reset so a reset edge never doubles as an accept.
    always_comb begin
        stateNext     = state;
        accept        = 1'b0;
        respDone      = 1'b0;
        bus.Req0Ready = 1'b0;
        bus.Req1Ready = 1'b0;
        case (state)
            IDLE: begin
                if (!Reset && (gnt != 2'b00)) begin
                    accept        = 1'b1;
                    bus.Req0Ready = gnt[0];
                    bus.Req1Ready = gnt[1];
                    stateNext     = EXEC;
                end
            end
            EXEC: stateNext = RESP;
            RESP: begin
                if (grantId ? bus.Resp1Ready : bus.Resp0Ready) begin
                    respDone  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // An illegal code is turned into PassB of zero so the ALU's behaviour on
    // unknown codes can never reach a requester.
    assign opLegal = is_legal_op(opCtrl);
    assign AluA    = opA;
    assign AluB    = opLegal ? opB : '0;
    assign AluCtrl = opLegal ? opCtrl : ALU_PASSB;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            grantId <= 1'b0;
            opA     <= '0;
            opB     <= '0;
            opCtrl  <= '0;
            resW    <= '0;
            resZero <= 1'b0;
            resErr  <= 1'b0;
        end else begin
            if (accept) begin
                grantId <= gnt[1];
                opA     <= gnt[1] ? bus.Req1A    : bus.Req0A;
                opB     <= gnt[1] ? bus.Req1B    : bus.Req0B;
                opCtrl  <= gnt[1] ? bus.Req1Ctrl : bus.Req0Ctrl;
            end
            if (state == EXEC) begin
                resW    <= opLegal ? AluW : '0;
                resZero <= opLegal ? AluZero : 1'b1;
                resErr  <= ~opLegal;
            end
        end
    end

    assign bus.Resp0Valid = (state == RESP) && !grantId;
    assign bus.Resp1Valid = (state == RESP) &&  grantId;
    assign bus.Resp0W     = resW;
    assign bus.Resp1W     = resW;
    assign bus.Resp0Zero  = resZero;
    assign bus.Resp1Zero  = resZero;
    assign bus.Resp0Err   = resErr;
    assign bus.Resp1Err   = resErr;
endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with a stand-in combinational ALU, a
// transaction-level reference model checked on every falling edge, and
// hand-computed literal expectations at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    localparam int DATA_W = 64;
    localparam int CTRL_W = 4;

    logic              CLK = 1'b0;
    logic              Reset = 1'b1;
    logic [DATA_W-1:0] AluA, AluB, AluW;
    logic [CTRL_W-1:0] AluCtrl;
    logic              AluZero;

    int checks = 0;
    int failures = 0;

    alu_arbiter_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .bus     (bus),
        .AluA    (AluA),
        .AluB    (AluB),
        .AluCtrl (AluCtrl),
        .AluW    (AluW),
        .AluZero (AluZero)
    );

    always #5 CLK = ~CLK;

    // Stand-in ALU; unknown codes yield junk so leaking it would be visible.
    always_comb begin
        case (AluCtrl)
            4'b0000: AluW = AluA & AluB;
            4'b0001: AluW = AluA | AluB;
            4'b0010: AluW = AluA + AluB;
            4'b0110: AluW = AluA - AluB;
            4'b0111: AluW = AluB;
            default: AluW = 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
        AluZero = (AluW == 64'd0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Returns {err, zero, w} for a request as a requester must observe it.
    function automatic logic [65:0] specResult(input logic [63:0] a, input logic [63:0] b,
                                               input logic [3:0] c);
        logic [63:0] w;
        logic        err;
        err = 1'b0;
        case (c)
            4'b0000: w = a & b;
            4'b0001: w = a | b;
            4'b0010: w = a + b;
            4'b0110: w = a - b;
            4'b0111: w = b;
            default: begin w = 64'd0; err = 1'b1; end
        endcase
        return {err, (w == 64'd0), w};
    endfunction

    // Reference model: mAge is cycles since accept (-1 when nothing in flight).
    bit          modelOn = 1'b0;
    int          mAge = -1;
    logic        mPtr = 1'b0;
    logic        mWho = 1'b0;
    logic [63:0] mA, mB;
    logic [3:0]  mCtrl;
    logic [65:0] mExp;
    logic [1:0]  er;

    always @(negedge CLK) begin
        if (modelOn) begin
            er = 2'b00;
            if (!Reset && mAge < 0) begin
                if (bus.Req0Valid && bus.Req1Valid) er[mPtr] = 1'b1;
                else if (bus.Req0Valid)             er[0]    = 1'b1;
                else if (bus.Req1Valid)             er[1]    = 1'b1;
            end
            chkBit("m_req0Ready", bus.Req0Ready, er[0]);
            chkBit("m_req1Ready", bus.Req1Ready, er[1]);
            chkBit("m_resp0Valid", bus.Resp0Valid, (mAge >= 2) && !mWho);
            chkBit("m_resp1Valid", bus.Resp1Valid, (mAge >= 2) &&  mWho);
            if (mAge >= 2) begin
                chk   ("m_respW",    mWho ? bus.Resp1W    : bus.Resp0W,    mExp[63:0]);
                chkBit("m_respZero", mWho ? bus.Resp1Zero : bus.Resp0Zero, mExp[64]);
                chkBit("m_respErr",  mWho ? bus.Resp1Err  : bus.Resp0Err,  mExp[65]);
            end
            if (mAge == 1) begin
                chk("m_aluA", AluA, mA);
                chk("m_aluB", AluB, mExp[65] ? 64'd0 : mB);
                chk("m_aluCtrl", 64'(AluCtrl), mExp[65] ? 64'd7 : 64'(mCtrl));
            end
            if (Reset) begin
                mAge = -1;
                mPtr = 1'b0;
            end else if (mAge < 0) begin
                if (er != 2'b00) begin
                    mWho  = er[1];
                    mA    = er[1] ? bus.Req1A    : bus.Req0A;
                    mB    = er[1] ? bus.Req1B    : bus.Req0B;
                    mCtrl = er[1] ? bus.Req1Ctrl : bus.Req0Ctrl;
                    mExp  = specResult(mA, mB, mCtrl);
                    mAge  = 1;
                end
            end else if (mAge == 1) begin
                mAge = 2;
            end else if (mWho ? bus.Resp1Ready : bus.Resp0Ready) begin
                mAge = -1;
                mPtr = ~mWho;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        bus.Req0Valid = 0; bus.Req1Valid = 0;
        bus.Req0A = 0; bus.Req0B = 0; bus.Req0Ctrl = 0;
        bus.Req1A = 0; bus.Req1B = 0; bus.Req1Ctrl = 0;
        bus.Resp0Ready = 0; bus.Resp1Ready = 0;
        Reset = 1;
        tick();
        modelOn = 1;
        tick();

        // Reset values
        chkBit("rst_req0Ready", bus.Req0Ready, 1'b0);
        chkBit("rst_resp0Valid", bus.Resp0Valid, 1'b0);
        chkBit("rst_resp1Valid", bus.Resp1Valid, 1'b0);
        chk   ("rst_resp0W", bus.Resp0W, 64'd0);
        chkBit("rst_resp0Zero", bus.Resp0Zero, 1'b0);
        chkBit("rst_resp1Err", bus.Resp1Err, 1'b0);
        chk   ("rst_aluA", AluA, 64'd0);
        chk   ("rst_aluB", AluB, 64'd0);
        chk   ("rst_aluCtrl", 64'(AluCtrl), 64'd0);
        Reset = 0;
        tick();

        // Single op: 5 + 3
        bus.Req0Valid = 1; bus.Req0A = 64'd5; bus.Req0B = 64'd3; bus.Req0Ctrl = 4'b0010;
        #1;
        chkBit("single_req0Ready_T", bus.Req0Ready, 1'b1);
        tick();
        bus.Req0Valid = 0; bus.Req0A = 64'hFFFF;
        chk   ("single_aluA_T1", AluA, 64'd5);
        chkBit("single_resp0Valid_T1", bus.Resp0Valid, 1'b0);
        tick();
        chkBit("single_resp0Valid_T2", bus.Resp0Valid, 1'b1);
        chk   ("single_resp0W", bus.Resp0W, 64'd8);
        chkBit("single_resp0Zero", bus.Resp0Zero, 1'b0);
        chkBit("single_resp0Err", bus.Resp0Err, 1'b0);
        bus.Resp0Ready = 1;
        tick();
        bus.Resp0Ready = 0;

        // Zero flag from SUB on requester 1
        bus.Req1Valid = 1; bus.Req1A = 64'h1234; bus.Req1B = 64'h1234; bus.Req1Ctrl = 4'b0110;
        #1;
        chkBit("zero_req1Ready", bus.Req1Ready, 1'b1);
        chkBit("zero_req0Ready", bus.Req0Ready, 1'b0);
        tick();
        bus.Req1Valid = 0;
        tick();
        chkBit("zero_resp1Valid", bus.Resp1Valid, 1'b1);
        chkBit("zero_resp0Valid", bus.Resp0Valid, 1'b0);
        chk   ("zero_resp1W", bus.Resp1W, 64'd0);
        chkBit("zero_resp1Zero", bus.Resp1Zero, 1'b1);
        bus.Resp1Ready = 1;
        tick();
        bus.Resp1Ready = 0;

        // Contention from reset: grants alternate 0,1,0,1
        Reset = 1;
        tick();
        Reset = 0;
        bus.Req0A = 64'hF0; bus.Req0B = 64'h3C; bus.Req0Ctrl = 4'b0000;
        bus.Req1A = 64'hF0; bus.Req1B = 64'h3C; bus.Req1Ctrl = 4'b0001;
        bus.Req0Valid = 1; bus.Req1Valid = 1;
        bus.Resp0Ready = 1; bus.Resp1Ready = 1;
        #1;
        for (int k = 0; k < 4; k++) begin
            g = -1;
            for (int w = 0; w < 6; w++) begin
                if (bus.Req0Ready) begin g = 0; break; end
                if (bus.Req1Ready) begin g = 1; break; end
                tick();
            end
            chk("contend_grant", 64'(g), 64'(k % 2));
            tick();
            if (k == 3) begin
                bus.Req0Valid = 0; bus.Req1Valid = 0;
            end
            tick();
            if (g == 1) begin
                chkBit("contend_resp1Valid", bus.Resp1Valid, 1'b1);
                chk   ("contend_resp1W", bus.Resp1W, 64'hFC);
            end else begin
                chkBit("contend_resp0Valid", bus.Resp0Valid, 1'b1);
                chk   ("contend_resp0W", bus.Resp0W, 64'h30);
            end
            tick();
        end
        bus.Resp0Ready = 0; bus.Resp1Ready = 0;

        // Backpressure on response 0 while requester 1 waits
        bus.Req0A = 64'd7; bus.Req0B = 64'd9; bus.Req0Ctrl = 4'b0010;
        bus.Req1A = 64'd1; bus.Req1B = 64'd2; bus.Req1Ctrl = 4'b0001;
        bus.Req0Valid = 1; bus.Req1Valid = 1;
        #1;
        chkBit("bp_req0Ready", bus.Req0Ready, 1'b1);
        tick();
        bus.Req0Valid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chkBit("bp_resp0Valid", bus.Resp0Valid, 1'b1);
            chk   ("bp_resp0W", bus.Resp0W, 64'd16);
            chkBit("bp_req1Ready", bus.Req1Ready, 1'b0);
            tick();
        end
        bus.Resp0Ready = 1;
        tick();
        bus.Resp0Ready = 0;
        chkBit("bp_req1Ready_after", bus.Req1Ready, 1'b1);
        tick();
        bus.Req1Valid = 0;
        tick();
        chk("bp_resp1W", bus.Resp1W, 64'd3);
        bus.Resp1Ready = 1;
        tick();
        bus.Resp1Ready = 0;

        // Illegal control code
        bus.Req0A = 64'h55; bus.Req0B = 64'hAA; bus.Req0Ctrl = 4'b1111;
        bus.Req0Valid = 1;
        #1;
        chkBit("ill_req0Ready", bus.Req0Ready, 1'b1);
        tick();
        bus.Req0Valid = 0;
        chk("ill_aluCtrl", 64'(AluCtrl), 64'd7);
        chk("ill_aluB", AluB, 64'd0);
        tick();
        chk   ("ill_resp0W", bus.Resp0W, 64'd0);
        chkBit("ill_resp0Zero", bus.Resp0Zero, 1'b1);
        chkBit("ill_resp0Err", bus.Resp0Err, 1'b1);
        bus.Resp0Ready = 1;
        tick();
        bus.Resp0Ready = 0;

        // Reset while in EXEC drops the operation
        bus.Req1A = 64'd1; bus.Req1B = 64'd1; bus.Req1Ctrl = 4'b0010;
        bus.Req1Valid = 1;
        #1;
        chkBit("rexec_req1Ready", bus.Req1Ready, 1'b1);
        tick();
        bus.Req1Valid = 0;
        chk("rexec_aluA_exec", AluA, 64'd1);
        Reset = 1;
        tick();
        Reset = 0;
        chkBit("rexec_resp1Valid", bus.Resp1Valid, 1'b0);
        chk   ("rexec_aluA", AluA, 64'd0);
        chk   ("rexec_aluCtrl", 64'(AluCtrl), 64'd0);
        chk   ("rexec_resp1W", bus.Resp1W, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chkBit("rexec_noResp1", bus.Resp1Valid, 1'b0);
            tick();
        end
        bus.Req0A = 64'd10; bus.Req0B = 64'd4; bus.Req0Ctrl = 4'b0110;
        bus.Req1A = 64'd3;  bus.Req1B = 64'd3; bus.Req1Ctrl = 4'b0000;
        bus.Req0Valid = 1; bus.Req1Valid = 1;
        #1;
        chkBit("rexec_ptr0_req0Ready", bus.Req0Ready, 1'b1);
        chkBit("rexec_ptr0_req1Ready", bus.Req1Ready, 1'b0);
        tick();
        bus.Req0Valid = 0; bus.Req1Valid = 0;
        tick();
        chk   ("rexec_resp0W", bus.Resp0W, 64'd6);
        chkBit("rexec_resp0Zero", bus.Resp0Zero, 1'b0);
        bus.Resp0Ready = 1;
        tick();
        bus.Resp0Ready = 0;
        tick();
        tick();

        modelOn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared 64-bit ALU. Accepts operations from two independent requesters over valid/ready handshakes, grants the ALU round-robin, and drives the ALU's operand and control inputs from registered copies. It captures the ALU result and zero flag and returns them to the winning requester over a valid/ready response channel. It sits between the fetch/execute sequencing logic and the ALU instance, so that an address/branch unit and the main execute path can share one ALU.

## Interface
- DATA_W, 64, operand/result width (matches ALU BusA/BusB/BusW)
- CTRL_W, 4, ALU control code width

- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Req0Valid / Req1Valid  in  1  requester N has an operation pending
- Req0Ready / Req1Ready  out  1  operation of requester N accepted this cycle
- Req0A, Req0B / Req1A, Req1B  in  DATA_W  operands
- Req0Ctrl / Req1Ctrl  in  CTRL_W  ALU control code
- Resp0Valid / Resp1Valid  out  1  result for requester N available
- Resp0Ready / Resp1Ready  in  1  requester N consumes result
- Resp0W / Resp1W  out  DATA_W  result
- Resp0Zero / Resp1Zero  out  1  zero flag of result
- Resp0Err / Resp1Err  out  1  control code was not a legal ALU op
- AluA, AluB  out  DATA_W  to ALU BusA/BusB
- AluCtrl  out  CTRL_W  to ALU ALUCtrl
- AluW  in  DATA_W  from ALU BusW
- AluZero  in  1  from ALU Zero

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if either ReqNValid is high, grant one requester. ReqNReady is high combinationally for the grantee only, in this cycle only. Latch A, B, Ctrl and the grant id into registers. Go to EXEC.
- Grant rule: if only one requester is valid, it wins. If both are valid, the requester selected by the priority pointer wins.
- Priority pointer: resets to 0. When a response handshake completes, the pointer moves to the requester that was not just served.
- EXEC: AluA, AluB and AluCtrl come from the registers (the ALU is combinational). At the clock edge, capture AluW and AluZero into the result registers. Go to RESP.
- Legal codes: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111.
- Illegal code in EXEC: AluCtrl is driven as PassB with AluB = 0. The captured result is W = 0, Zero = 1, and Err = 1. The stale-output behaviour of the ALU is never exposed to a requester.
- RESP: RespNValid is high for the grantee only. RespW, RespZero and RespErr stay stable until RespNReady is high. On that handshake, update the pointer and go to IDLE.
- A non-granted requester keeps Valid asserted and its operands stable until it sees Ready. Operand changes made before Ready are not observed.
- Arithmetic: ADD and SUB wrap modulo 2^64. There is no carry or overflow output.

## Timing
- Accept at cycle T (Valid and Ready both high). ALU evaluates in T+1. RespValid is high from T+2.
- Minimum spacing is 3 cycles per operation. The next accept can occur in the cycle after the response handshake.
- Response backpressure holds the FSM in RESP. No new request is accepted while in EXEC or RESP; ReqNReady is 0 in those states.
- Reset values:
  - state IDLE, pointer 0
  - ReqNReady 0 (no Valid is high during reset)
  - RespNValid 0, RespNW 0, RespNZero 0, RespNErr 0
  - AluA 0, AluB 0, AluCtrl 0000
- Reset asserted mid-operation, in any state: the operation is dropped, no response is produced, and all registers take their reset values on that edge.
- Reset has priority over every handshake in the same cycle.

## Structure
- Shared package alu_ctrl_pkg contains:
  - the five ALU op-code constants, which the ALU also uses
  - the FSM state encoding
  - an is_legal_op function
- Sub-module rr_arbiter_2 is a 2-way round-robin grant with a pointer-update input. The top level contains the FSM, the operand/result registers and the legality check.

## Test plan
- Single op: Req0 sends A=5, B=3, Ctrl=0010 → Req0Ready at T, Resp0Valid at T+2 with W=8, Zero=0, Err=0.
- Zero flag: Req1 sends A=B=0x1234, Ctrl=0110 → W=0, Zero=1; Resp1Valid only, Resp0Valid stays 0.
- Contention: both requesters valid continuously from reset → grants alternate 0,1,0,1. Each result returns to the correct port (Req0 is AND F0&3C → 0x30; Req1 is OR → 0xFC).
- Backpressure: Resp0Ready held low for 5 cycles → Resp0W stays stable, FSM stays in RESP, Req1Ready stays 0 despite Req1Valid; after the handshake, Req1 is granted on the next cycle.
- Illegal code: Ctrl=1111 → W=0, Zero=1, Err=1, and AluCtrl observed as 0111 during EXEC.
- Reset in EXEC: assert Reset for one cycle → no RespValid follows; outputs at reset values; the next request is accepted normally with the pointer at 0.
